// File: rtl/pep_gram_arbiter.sv
// Per-bank access arbiter for the GLWE RAM: round-robin grant per bank, registered bank command,
// read-return routing and a starvation monitor. Define PEP_GRAM_ARB_ACC_PRIO_EN for actor-0 strict priority.
module pep_gram_arbiter #(
  parameter int GRAM_NB    = 4,
  parameter int ACTOR_NB   = 4,
  parameter int ADD_W      = 16,
  parameter int DATA_W     = 64,
  parameter int RAM_RD_LAT = 2,
  parameter int STARVE_MAX = 255,
  localparam int GID_W = (GRAM_NB > 1) ? $clog2(GRAM_NB) : 1,
  localparam int AID_W = (ACTOR_NB > 1) ? $clog2(ACTOR_NB) : 1
) (
  input  logic                        clk,
  input  logic                        a_rst_n,
  input  logic [ACTOR_NB-1:0]         req_vld,
  output logic [ACTOR_NB-1:0]         req_rdy,
  input  logic [ACTOR_NB*GID_W-1:0]   req_gid,
  input  logic [ACTOR_NB-1:0]         req_we,
  input  logic [ACTOR_NB*ADD_W-1:0]   req_add,
  input  logic [ACTOR_NB*DATA_W-1:0]  req_wdata,
  output logic [GRAM_NB-1:0]          ram_en,
  output logic [GRAM_NB-1:0]          ram_we,
  output logic [GRAM_NB*ADD_W-1:0]    ram_add,
  output logic [GRAM_NB*DATA_W-1:0]   ram_wdata,
  input  logic [GRAM_NB*DATA_W-1:0]   ram_rdata,
  output logic [ACTOR_NB-1:0]         rsp_vld,
  output logic [ACTOR_NB*DATA_W-1:0]  rsp_data,
  output logic                        error
);

  localparam int CNT_RAW = $clog2(STARVE_MAX + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_MAX);

  function automatic logic [AID_W-1:0] wrap_id(input logic [AID_W-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % ACTOR_NB;
    return sum[AID_W-1:0];
  endfunction

  logic [ACTOR_NB-1:0]         cand_s [GRAM_NB];
  logic [GRAM_NB-1:0]          gnt_vld_s;
  logic [AID_W-1:0]            gnt_id_s [GRAM_NB];
  logic [AID_W-1:0]            scan_id_s;
  logic                        scan_hit_s;
  logic [AID_W-1:0]            rr_d [GRAM_NB];
  logic [AID_W-1:0]            rr_q [GRAM_NB];
  logic [ACTOR_NB-1:0]         req_rdy_s;

  logic [GRAM_NB-1:0]          ram_en_d, ram_en_q;
  logic [GRAM_NB-1:0]          ram_we_d, ram_we_q;
  logic [GRAM_NB*ADD_W-1:0]    ram_add_d, ram_add_q;
  logic [GRAM_NB*DATA_W-1:0]   ram_wdata_d, ram_wdata_q;
  logic [AID_W-1:0]            ram_id_q [GRAM_NB];

  logic [RAM_RD_LAT-1:0]       pipe_vld_q [GRAM_NB];
  logic [AID_W-1:0]            pipe_id_q [GRAM_NB][RAM_RD_LAT];
  logic [ACTOR_NB-1:0]         rsp_vld_d, rsp_vld_q;
  logic [ACTOR_NB*DATA_W-1:0]  rsp_data_d, rsp_data_q;
  logic                        rsp_hit_s;

  logic [CNT_W-1:0]            cnt_d [ACTOR_NB];
  logic [CNT_W-1:0]            cnt_q [ACTOR_NB];
  logic                        err_d, err_q;

  // Candidate matrix: actor a wants bank b.
  always_comb begin
    for (int b = 0; b < GRAM_NB; b++) begin
      for (int a = 0; a < ACTOR_NB; a++) begin
        cand_s[b][a] = req_vld[a] && (req_gid[a*GID_W +: GID_W] == GID_W'(b));
      end
    end
  end

  // Per-bank grant: first candidate at or after rr, scanning with wrap; pointer advance.
  always_comb begin
    scan_id_s  = '0;
    scan_hit_s = 1'b0;
    for (int b = 0; b < GRAM_NB; b++) begin
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
      gnt_vld_s[b] = cand_s[b][0];
`else
      gnt_vld_s[b] = 1'b0;
`endif
      gnt_id_s[b] = '0;
      for (int k = 0; k < ACTOR_NB; k++) begin
        scan_id_s = wrap_id(rr_q[b], k);
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
        scan_hit_s = !gnt_vld_s[b] && (scan_id_s != '0) && cand_s[b][scan_id_s];
`else
        scan_hit_s = !gnt_vld_s[b] && cand_s[b][scan_id_s];
`endif
        gnt_id_s[b]  = scan_hit_s ? scan_id_s : gnt_id_s[b];
        gnt_vld_s[b] = gnt_vld_s[b] | scan_hit_s;
      end
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
      // A priority grant to actor 0 leaves the pointer of the other actors untouched.
      rr_d[b] = (gnt_vld_s[b] && (gnt_id_s[b] != '0)) ? wrap_id(gnt_id_s[b], 1) : rr_q[b];
`else
      rr_d[b] = gnt_vld_s[b] ? wrap_id(gnt_id_s[b], 1) : rr_q[b];
`endif
    end
  end

  // Ready back to each actor from whichever bank granted it.
  always_comb begin
    req_rdy_s = '0;
    for (int a = 0; a < ACTOR_NB; a++) begin
      for (int b = 0; b < GRAM_NB; b++) begin
        req_rdy_s[a] = req_rdy_s[a] | (gnt_vld_s[b] && (gnt_id_s[b] == AID_W'(a)));
      end
    end
  end

  // Next bank command: winner fields on a grant, address/data hold otherwise.
  always_comb begin
    ram_en_d    = gnt_vld_s;
    ram_we_d    = '0;
    ram_add_d   = ram_add_q;
    ram_wdata_d = ram_wdata_q;
    for (int b = 0; b < GRAM_NB; b++) begin
      ram_we_d[b] = gnt_vld_s[b] & req_we[gnt_id_s[b]];
      ram_add_d[b*ADD_W +: ADD_W] = gnt_vld_s[b] ?
        req_add[int'(gnt_id_s[b])*ADD_W +: ADD_W] : ram_add_q[b*ADD_W +: ADD_W];
      ram_wdata_d[b*DATA_W +: DATA_W] = gnt_vld_s[b] ?
        req_wdata[int'(gnt_id_s[b])*DATA_W +: DATA_W] : ram_wdata_q[b*DATA_W +: DATA_W];
    end
  end

  // Route each bank's pipe output to its requesting actor; data holds when idle.
  always_comb begin
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    rsp_hit_s  = 1'b0;
    for (int a = 0; a < ACTOR_NB; a++) begin
      for (int b = 0; b < GRAM_NB; b++) begin
        rsp_hit_s = pipe_vld_q[b][RAM_RD_LAT-1] && (pipe_id_q[b][RAM_RD_LAT-1] == AID_W'(a));
        rsp_vld_d[a] = rsp_vld_d[a] | rsp_hit_s;
        rsp_data_d[a*DATA_W +: DATA_W] = rsp_hit_s ?
          ram_rdata[b*DATA_W +: DATA_W] : rsp_data_d[a*DATA_W +: DATA_W];
      end
    end
  end

  // Starvation counters saturate at STARVE_MAX; error fires only on the arrival step.
  always_comb begin
    err_d = 1'b0;
    for (int a = 0; a < ACTOR_NB; a++) begin
      if (!req_vld[a] || req_rdy_s[a]) begin
        cnt_d[a] = '0;
      end else if (cnt_q[a] == STARVE_C) begin
        cnt_d[a] = cnt_q[a];
      end else begin
        cnt_d[a] = cnt_q[a] + CNT_W'(1);
      end
      err_d = err_d | ((cnt_d[a] == STARVE_C) && (cnt_q[a] != STARVE_C));
    end
  end

  // Arbitration state, bank command and starvation registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      ram_en_q    <= '0;
      ram_we_q    <= '0;
      ram_add_q   <= '0;
      ram_wdata_q <= '0;
      err_q       <= 1'b0;
      for (int b = 0; b < GRAM_NB; b++) begin
        rr_q[b]     <= '0;
        ram_id_q[b] <= '0;
      end
      for (int a = 0; a < ACTOR_NB; a++) begin
        cnt_q[a] <= '0;
      end
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_add_q   <= ram_add_d;
      ram_wdata_q <= ram_wdata_d;
      err_q       <= err_d;
      for (int b = 0; b < GRAM_NB; b++) begin
        rr_q[b]     <= rr_d[b];
        ram_id_q[b] <= gnt_id_s[b];
      end
      for (int a = 0; a < ACTOR_NB; a++) begin
        cnt_q[a] <= cnt_d[a];
      end
    end
  end

  // Read-return pipes and response registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      for (int b = 0; b < GRAM_NB; b++) begin
        pipe_vld_q[b] <= '0;
        for (int s = 0; s < RAM_RD_LAT; s++) begin
          pipe_id_q[b][s] <= '0;
        end
      end
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      for (int b = 0; b < GRAM_NB; b++) begin
        pipe_vld_q[b][0] <= ram_en_q[b] & ~ram_we_q[b];
        pipe_id_q[b][0]  <= ram_id_q[b];
        for (int s = 1; s < RAM_RD_LAT; s++) begin
          pipe_vld_q[b][s] <= pipe_vld_q[b][s-1];
          pipe_id_q[b][s]  <= pipe_id_q[b][s-1];
        end
      end
    end
  end

  assign req_rdy   = req_rdy_s;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_add   = ram_add_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_data  = rsp_data_q;
  assign error     = err_q;

endmodule

// File: tb/tb_pep_gram_arbiter.sv
// Self-checking bench for pep_gram_arbiter: vector table, reference arbiter, bank RAM model
// and a per-actor response scoreboard. Honours PEP_GRAM_ARB_ACC_PRIO_EN.
module tb_pep_gram_arbiter;
  localparam int GN = 4, AN = 4, AW = 16, DW = 64, LAT = 2, SMAX = 255;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic [AN-1:0]    req_vld, req_rdy, req_we, rsp_vld;
  logic [AN*2-1:0]  req_gid;
  logic [AN*AW-1:0] req_add;
  logic [AN*DW-1:0] req_wdata, rsp_data;
  logic [GN-1:0]    ram_en, ram_we;
  logic [GN*AW-1:0] ram_add;
  logic [GN*DW-1:0] ram_wdata, ram_rdata;
  logic             error;

  pep_gram_arbiter #(.GRAM_NB(GN), .ACTOR_NB(AN), .ADD_W(AW), .DATA_W(DW),
                     .RAM_RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_gid(req_gid),
    .req_we(req_we), .req_add(req_add), .req_wdata(req_wdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_add(ram_add), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rsp_vld(rsp_vld),
    .rsp_data(rsp_data), .error(error));

  always #5 clk = ~clk;

  logic [AN-1:0] vld_r = '0, we_r = '0;
  logic [1:0]    gid_r [AN];
  logic [AW-1:0] add_r [AN];
  logic [DW-1:0] wd_r  [AN];

  always_comb begin
    req_vld = vld_r;
    req_we  = we_r;
    for (int a = 0; a < AN; a++) begin
      req_gid[a*2 +: 2]    = gid_r[a];
      req_add[a*AW +: AW]  = add_r[a];
      req_wdata[a*DW +: DW] = wd_r[a];
    end
  end

  function automatic logic [DW-1:0] init_val(int b, int i);
    return 64'hC0DE_0000_0000_0000 | (64'(b) << 8) | 64'(i);
  endfunction

  // Bank RAM model: rdata valid LAT cycles after the registered command.
  logic [DW-1:0] mem [GN][256];
  logic [DW-1:0] rd_pipe [GN][LAT];
  always @(posedge clk) begin
    for (int b = 0; b < GN; b++) begin
      if (!a_rst_n) begin
        for (int i = 0; i < 256; i++) mem[b][i] <= init_val(b, i);
      end else if (ram_en[b] && ram_we[b]) begin
        mem[b][ram_add[b*AW +: 8]] <= ram_wdata[b*DW +: DW];
      end
      rd_pipe[b][0] <= mem[b][ram_add[b*AW +: 8]];
      for (int s = 1; s < LAT; s++) rd_pipe[b][s] <= rd_pipe[b][s-1];
    end
  end
  always_comb for (int b = 0; b < GN; b++) ram_rdata[b*DW +: DW] = rd_pipe[b][LAT-1];

  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq [AN][$];
  logic [DW-1:0] exp_mem [GN][256];
  int rr_m [GN];
  int cnt_m [AN];
  int cyc = 0, n_vec = 0, n_bad = 0;
  int err_cnt = 0, err_cyc = 0;
  int g_cnt [AN];
  logic [AN-1:0] rdy_seen;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic int pick(int b);
    int w;
    w = -1;
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
    if (vld_r[0] && int'(gid_r[0]) == b) return 0;
`endif
    for (int k = 0; k < AN; k++) begin
      int a;
      a = (rr_m[b] + k) % AN;
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
      if (a == 0) continue;
`endif
      if (w < 0 && vld_r[a] && int'(gid_r[a]) == b) w = a;
    end
    return w;
  endfunction

  // One clock: check ready against the reference, predict, advance, check registered outputs.
  task automatic tick();
    logic [AN-1:0] g;
    logic [GN-1:0] e_en, e_we;
    logic [AW-1:0] e_add [GN];
    logic [DW-1:0] e_wd [GN];
    logic e_err;
    int w, nc;
    #1;
    g = '0; e_en = '0; e_we = '0; e_err = 1'b0;
    for (int b = 0; b < GN; b++) begin
      e_add[b] = '0; e_wd[b] = '0;
      w = pick(b);
      if (w >= 0) begin
        g[w] = 1'b1; e_en[b] = 1'b1; e_we[b] = we_r[w]; e_add[b] = add_r[w]; e_wd[b] = wd_r[w];
        if (we_r[w]) exp_mem[b][add_r[w][7:0]] = wd_r[w];
        else rq[w].push_back('{cyc + 2 + LAT, exp_mem[b][add_r[w][7:0]]});
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
        if (w != 0) rr_m[b] = (w + 1) % AN;
`else
        rr_m[b] = (w + 1) % AN;
`endif
      end
    end
    rdy_seen = req_rdy;
    chk("req_rdy", req_rdy, g);
    for (int a = 0; a < AN; a++) begin
      g_cnt[a] += int'(rdy_seen[a]);
      nc = (!vld_r[a] || g[a]) ? 0 : ((cnt_m[a] < SMAX) ? cnt_m[a] + 1 : cnt_m[a]);
      if (nc == SMAX && cnt_m[a] != SMAX) e_err = 1'b1;
      cnt_m[a] = nc;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("ram_en", ram_en, e_en);
    chk("ram_we", ram_we, e_we);
    for (int b = 0; b < GN; b++) begin
      if (e_en[b]) chk("ram_add", ram_add[b*AW +: AW], e_add[b]);
      if (e_we[b]) chk("ram_wdata", ram_wdata[b*DW +: DW], e_wd[b]);
    end
    for (int a = 0; a < AN; a++) begin
      if (rsp_vld[a]) begin
        if (rq[a].size() == 0) chk("rsp_spurious", 64'(a), 64'hFFFF);
        else begin
          rsp_t r;
          r = rq[a].pop_front();
          chk("rsp_due", 64'(cyc), 64'(r.due));
          chk("rsp_data", rsp_data[a*DW +: DW], r.data);
        end
      end else if (rq[a].size() > 0 && rq[a][0].due <= cyc) begin
        chk("rsp_missing", 64'(a), 64'hFFFF);
        void'(rq[a].pop_front());
      end
    end
    chk("error", 64'(error), 64'(e_err));
    if (error) begin err_cnt++; err_cyc = cyc; end
  endtask

  task automatic do_reset();
    a_rst_n = 1'b0;
    vld_r = '0; we_r = '0;
    #1;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_add", 64'(ram_add), 0);
    chk("rst_ram_wdata", ram_wdata[63:0] | ram_wdata[255:192], 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_data", rsp_data[63:0] | rsp_data[255:192], 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_req_rdy", req_rdy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst_n = 1'b1;
    for (int b = 0; b < GN; b++) begin
      rr_m[b] = 0;
      for (int i = 0; i < 256; i++) exp_mem[b][i] = init_val(b, i);
    end
    for (int a = 0; a < AN; a++) begin cnt_m[a] = 0; rq[a].delete(); g_cnt[a] = 0; end
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [7:0]  gid;
    logic        we;
    logic [15:0] add;
    logic [63:0] wd;
    logic [3:0]  rdy;
  } vec_t;
  vec_t tab [19];

  initial begin
    int start, gsum;
    for (int a = 0; a < AN; a++) begin gid_r[a] = '0; add_r[a] = '0; wd_r[a] = '0; end
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
    tab[0] = '{4'b1110, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b0010};
    tab[1] = '{4'b1110, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b0100};
    tab[2] = '{4'b1110, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b1000};
    tab[3] = '{4'b1110, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b0010};
    tab[4] = '{4'b1110, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b0100};
    tab[5] = '{4'b1110, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b1000};
    tab[6] = '{4'b0000, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b0000};
    tab[7] = '{4'b0000, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'b0000};
`else
    for (int i = 0; i < 8; i++) tab[i] = '{4'b1111, 8'b10101010, 1'b0, 16'h0020, 64'h0, 4'(1 << (i % 4))};
`endif
    for (int i = 8; i < 19; i++) tab[i] = '{4'b0000, 8'b0, 1'b0, 16'h0011, 64'h0, 4'b0000};
    tab[12] = '{4'b0010, 8'b0, 1'b1, 16'h0011, 64'hDEAD, 4'b0010};
    tab[14] = '{4'b0010, 8'b0, 1'b0, 16'h0011, 64'h0, 4'b0010};

    do_reset();

    // Table: shared-bank round robin, then write/read-back through bank 0.
    for (int i = 0; i < 19; i++) begin
      vld_r = tab[i].vld;
      we_r  = {4{tab[i].we}};
      for (int a = 0; a < AN; a++) begin
        gid_r[a] = tab[i].gid[2*a +: 2];
        add_r[a] = tab[i].add + AW'(a);
        wd_r[a]  = tab[i].wd;
      end
      #1 chk("tab_rdy", req_rdy, tab[i].rdy);
      tick();
    end

    // Distinct banks: full throughput.
    gsum = 0;
    vld_r = 4'b1111; we_r = '0;
    for (int a = 0; a < AN; a++) begin gid_r[a] = 2'(a); add_r[a] = AW'(16'h40 + a); end
    for (int i = 0; i < 100; i++) begin
      tick();
      gsum += $countones(rdy_seen);
    end
    chk("throughput", 64'(gsum), 64'd400);
    vld_r = '0;
    repeat (LAT + 3) tick();

    // Reset with two reads in flight.
    vld_r = 4'b0011; gid_r[0] = 2'd0; gid_r[1] = 2'd1; add_r[0] = 16'h5; add_r[1] = 16'h6;
    tick();
    vld_r = '0;
    tick();
    do_reset();
    repeat (LAT + 3) tick();
    vld_r = 4'b1111;
    for (int a = 0; a < AN; a++) gid_r[a] = 2'd0;
    #1 chk("rr_after_reset", req_rdy, 4'b0001);
    vld_r = '0;
    repeat (2) tick();

    // Actors 0 and 3 contend for bank 1 for 300 cycles.
    for (int a = 0; a < AN; a++) g_cnt[a] = 0;
    err_cnt = 0; err_cyc = 0;
    vld_r = 4'b1001; we_r = '0; gid_r[0] = 2'd1; gid_r[3] = 2'd1; add_r[0] = 16'h30; add_r[3] = 16'h33;
    start = cyc;
    repeat (300) tick();
    vld_r = '0;
    repeat (LAT + 3) tick();
`ifdef PEP_GRAM_ARB_ACC_PRIO_EN
    chk("prio_g0", 64'(g_cnt[0]), 64'd300);
    chk("prio_g3", 64'(g_cnt[3]), 64'd0);
    chk("starve_pulses", 64'(err_cnt), 64'd1);
    chk("starve_cycle", 64'(err_cyc - start), 64'(SMAX));
`else
    chk("rr_g0", 64'(g_cnt[0]), 64'd150);
    chk("rr_g3", 64'(g_cnt[3]), 64'd150);
    chk("no_starve", 64'(err_cnt), 64'd0);
`endif
    gsum = 0;
    for (int a = 0; a < AN; a++) gsum += rq[a].size();
    chk("sb_drain", 64'(gsum), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
